// File: rtl/vector_rasterizer_if.sv
// Line-queue and framebuffer-write signal bundle for the vector rasterizer.
// The master side is the rasterizer; the slave side is the queue/framebuffer environment.
interface vector_rasterizer_if;
    logic signed [10:0] QStartX;
    logic signed [10:0] QStartY;
    logic signed [10:0] QEndX;
    logic signed [10:0] QEndY;
    logic [2:0]         QColor;
    logic               empty;
    logic               read;
    logic [10:0]        pixX;
    logic [10:0]        pixY;
    logic [2:0]         pixColor;
    logic               pixWrite;
    logic               pixReady;
    logic               busy;

    modport master (
        input  QStartX, QStartY, QEndX, QEndY, QColor, empty, pixReady,
        output read, pixX, pixY, pixColor, pixWrite, busy
    );

    modport slave (
        output QStartX, QStartY, QEndX, QEndY, QColor, empty, pixReady,
        input  read, pixX, pixY, pixColor, pixWrite, busy
    );
endinterface

// File: rtl/vector_rasterizer.sv
// Pops beam-space lines from the AVG queue, walks them with Bresenham and
// emits clipped screen-space pixel writes over a valid/ready handshake.
module vector_rasterizer #(
    parameter int WIDTH    = 640,
    parameter int HEIGHT   = 480,
    parameter int ORIGIN_X = 320,
    parameter int ORIGIN_Y = 240
) (
    input  logic                 clk,
    input  logic                 rst,
    vector_rasterizer_if.master  bus
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SETUP = 2'd1;
    localparam logic [1:0] ST_DRAW  = 2'd2;

    logic [1:0]         state_r;
    logic signed [10:0] x0_r, y0_r, x1_r, y1_r, cx_r, cy_r;
    logic [2:0]         col_r;
    logic signed [11:0] dx_r, dy_r;
    logic               sx_neg_r, sy_neg_r;
    logic signed [12:0] err_r;

    logic signed [11:0] ddx_s, ddy_s, adx_s, ady_s;
    logic signed [12:0] sxs_s, sys_s, err_nxt_s;
    logic signed [13:0] e2_s, dx_e_s, dy_e_s;
    logic               vis_s, consume_s, last_s, step_x_s, step_y_s;

    // Line setup arithmetic: absolute deltas from the captured endpoints.
    always_comb begin
        ddx_s = {x1_r[10], x1_r} - {x0_r[10], x0_r};
        ddy_s = {y1_r[10], y1_r} - {y0_r[10], y0_r};
        if (ddx_s[11]) begin
            adx_s = -ddx_s;
        end else begin
            adx_s = ddx_s;
        end
        if (ddy_s[11]) begin
            ady_s = -ddy_s;
        end else begin
            ady_s = ddy_s;
        end
    end

    // Beam-to-screen translation, visibility window and Bresenham step decision.
    always_comb begin
        sxs_s     = {{2{cx_r[10]}}, cx_r} + 13'(ORIGIN_X);
        sys_s     = 13'(ORIGIN_Y) - {{2{cy_r[10]}}, cy_r};
        vis_s     = !sxs_s[12] && (sxs_s < 13'(WIDTH)) &&
                    !sys_s[12] && (sys_s < 13'(HEIGHT));
        consume_s = (state_r == ST_DRAW) && (!vis_s || bus.pixReady);
        last_s    = (cx_r == x1_r) && (cy_r == y1_r);
        e2_s      = {err_r, 1'b0};
        dx_e_s    = {{2{dx_r[11]}}, dx_r};
        dy_e_s    = {{2{dy_r[11]}}, dy_r};
        step_x_s  = (e2_s >= dy_e_s);
        step_y_s  = (e2_s <= dx_e_s);
        err_nxt_s = err_r;
        if (step_x_s) begin
            err_nxt_s = err_nxt_s + {dy_r[11], dy_r};
        end else begin
            err_nxt_s = err_nxt_s;
        end
        if (step_y_s) begin
            err_nxt_s = err_nxt_s + {dx_r[11], dx_r};
        end else begin
            err_nxt_s = err_nxt_s;
        end
    end

    // Queue pop strobe and pixel outputs; pixel fields are zero unless a visible point is presented.
    always_comb begin
        bus.read     = 1'b0;
        bus.pixWrite = 1'b0;
        bus.pixX     = 11'd0;
        bus.pixY     = 11'd0;
        bus.pixColor = 3'd0;
        bus.busy     = (state_r != ST_IDLE);
        if ((state_r == ST_IDLE) && !bus.empty) begin
            bus.read = 1'b1;
        end else begin
            bus.read = 1'b0;
        end
        if ((state_r == ST_DRAW) && vis_s) begin
            bus.pixWrite = 1'b1;
            bus.pixX     = sxs_s[10:0];
            bus.pixY     = sys_s[10:0];
            bus.pixColor = col_r;
        end else begin
            bus.pixWrite = 1'b0;
        end
    end

    // Line FSM: capture, one-cycle setup, then one point per consume.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            x0_r     <= 11'sd0;
            y0_r     <= 11'sd0;
            x1_r     <= 11'sd0;
            y1_r     <= 11'sd0;
            cx_r     <= 11'sd0;
            cy_r     <= 11'sd0;
            col_r    <= 3'd0;
            dx_r     <= 12'sd0;
            dy_r     <= 12'sd0;
            sx_neg_r <= 1'b0;
            sy_neg_r <= 1'b0;
            err_r    <= 13'sd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (!bus.empty) begin
                        x0_r    <= bus.QStartX;
                        y0_r    <= bus.QStartY;
                        x1_r    <= bus.QEndX;
                        y1_r    <= bus.QEndY;
                        col_r   <= bus.QColor;
                        state_r <= ST_SETUP;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_SETUP: begin
                    dx_r     <= adx_s;
                    dy_r     <= -ady_s;
                    sx_neg_r <= !(x0_r < x1_r);
                    sy_neg_r <= !(y0_r < y1_r);
                    err_r    <= {adx_s[11], adx_s} - {ady_s[11], ady_s};
                    cx_r     <= x0_r;
                    cy_r     <= y0_r;
                    state_r  <= ST_DRAW;
                end
                ST_DRAW: begin
                    if (consume_s && last_s) begin
                        state_r <= ST_IDLE;
                    end else if (consume_s) begin
                        err_r <= err_nxt_s;
                        if (step_x_s) begin
                            cx_r <= sx_neg_r ? (cx_r - 11'sd1) : (cx_r + 11'sd1);
                        end else begin
                            cx_r <= cx_r;
                        end
                        if (step_y_s) begin
                            cy_r <= sy_neg_r ? (cy_r - 11'sd1) : (cy_r + 11'sd1);
                        end else begin
                            cy_r <= cy_r;
                        end
                    end else begin
                        state_r <= ST_DRAW;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
